spk_ram_arbiter: RTL and testbench

- Shares one read port of the pre-synaptic spike-train RAM among NUM_REQ sparse event-control engines of the same FC layer.
- Gates all access until the pre-synaptic layer reports its RAM loaded.
- Grants one read per cycle, round-robin, and returns tagged read data after the fixed RAM latency.
- Merges per-engine completion flags into the layer-level post_syn_RAM_loaded handshake for the next layer.

---
 rtl/spk_ram_arbiter_if.sv | 46 ++++
 rtl/spk_ram_arbiter.sv | 156 +++++++++++++++
 tb/tb_spk_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spk_ram_arbiter_if.sv
// rtl/spk_ram_arbiter_if.sv - engine/RAM bus bundle shared by spk_ram_arbiter
//
// Purpose: groups the per-engine request/response signals and the spike-train
// RAM read port into one bundle.
//   master : engine array plus RAM (drives req, req_ts, req_ic, eng_done, ram_rdata)
//   slave  : arbiter (drives grant, ram_en, ram_addr, rsp_valid, rsp_data)
// Ports carried:
//   req[NUM_REQ]        per-engine read request, held until granted
//   req_ts, req_ic      per-engine time step / channel, engine i in slice i
//   eng_done[NUM_REQ]   per-engine completion level
//   grant[NUM_REQ]      one-hot grant pulse
//   ram_en, ram_addr    RAM read port
//   ram_rdata           RAM read data
//   rsp_valid[NUM_REQ]  one-hot owner of rsp_data
//   rsp_data            registered RAM word, broadcast to all engines
interface spk_ram_arbiter_if #(
  parameter int NUM_REQ          = 4,
  parameter int TIME_STEPS       = 10,
  parameter int INPUT_CHANNELS   = 2,
  parameter int INPUT_FRAME_SIZE = 120,
  parameter int ADDR_WIDTH       = $clog2(TIME_STEPS * INPUT_CHANNELS)
);
  localparam int TS_W = $clog2(TIME_STEPS) + 2;
  localparam int IC_W = $clog2(INPUT_CHANNELS) + 2;

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*TS_W-1:0]     req_ts;
  logic [NUM_REQ*IC_W-1:0]     req_ic;
  logic [NUM_REQ-1:0]          eng_done;
  logic [NUM_REQ-1:0]          grant;
  logic                        ram_en;
  logic [ADDR_WIDTH-1:0]       ram_addr;
  logic [INPUT_FRAME_SIZE-1:0] ram_rdata;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [INPUT_FRAME_SIZE-1:0] rsp_data;

  modport master (
    output req, req_ts, req_ic, eng_done, ram_rdata,
    input  grant, ram_en, ram_addr, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_ts, req_ic, eng_done, ram_rdata,
    output grant, ram_en, ram_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spk_ram_arbiter.sv
// rtl/spk_ram_arbiter.sv - round-robin arbiter for the pre-synaptic spike-train RAM
//
// Purpose: shares one RAM read port among NUM_REQ event-control engines of an
// FC layer, gated by pre_syn_RAM_loaded, and raises post_syn_RAM_loaded once
// every engine is done and all reads have drained.
// Ports:
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   pre_syn_RAM_loaded   level, upstream spike RAM is valid
//   bus                  engine/RAM bundle (slave side)
//   post_syn_RAM_loaded  level, layer output ready
//   busy                 high while serving or draining
module spk_ram_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int TIME_STEPS       = 10,
  parameter int INPUT_CHANNELS   = 2,
  parameter int INPUT_FRAME_SIZE = 120,
  parameter int RAM_LATENCY      = 1,
  parameter int ADDR_WIDTH       = $clog2(TIME_STEPS * INPUT_CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pre_syn_RAM_loaded,
  spk_ram_arbiter_if.slave    bus,
  output logic                post_syn_RAM_loaded,
  output logic                busy
);
  localparam int TS_W  = $clog2(TIME_STEPS) + 2;
  localparam int IC_W  = $clog2(INPUT_CHANNELS) + 2;
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    WAIT_LOAD = 2'd0,
    SERVE     = 2'd1,
    DRAIN     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] tag_pipe [RAM_LATENCY];

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   idx;
  logic [TS_W-1:0]    win_ts;
  logic [IC_W-1:0]    win_ic;
  logic [31:0]        addr_full;
  logic               arb_en;
  logic               upstream_busy;

  // Arbitration starts in the very cycle the upstream RAM reports loaded, so
  // the first grant pulse lands in the first SERVE cycle.
  assign arb_en = (state == SERVE) || ((state == WAIT_LOAD) && pre_syn_RAM_loaded);

  // Round-robin search from rr_ptr. A requester whose grant is currently
  // showing is masked: its req is still the one being served this cycle.
  always_comb begin
    eligible  = bus.req & ~bus.grant;
    win_found = 1'b0;
    win_idx   = '0;
    win_ts    = '0;
    win_ic    = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
        win_ts    = bus.req_ts[idx*TS_W +: TS_W];
        win_ic    = bus.req_ic[idx*IC_W +: IC_W];
      end
    end
    addr_full = 32'(win_ts) * 32'(INPUT_CHANNELS) + 32'(win_ic);
  end

  // Reads still ahead of the final tag stage. The last stage is excluded: it
  // turns into rsp_valid on the same edge that moves DRAIN into DONE, which
  // keeps the drain within RAM_LATENCY+1 cycles.
  always_comb begin
    upstream_busy = |bus.grant;
    for (int i = 0; i < RAM_LATENCY - 1; i++) begin
      upstream_busy = upstream_busy | (|tag_pipe[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    busy                = 1'b0;
    post_syn_RAM_loaded = 1'b0;
    case (state)
      WAIT_LOAD: begin
        if (pre_syn_RAM_loaded) state_nxt = SERVE;
      end
      SERVE: begin
        busy = 1'b1;
        // pre_syn_RAM_loaded dropping here is deliberately ignored.
        if (&bus.eng_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!upstream_busy) state_nxt = DONE;
      end
      DONE: begin
        post_syn_RAM_loaded = 1'b1;
        if (!pre_syn_RAM_loaded) state_nxt = WAIT_LOAD;
      end
      default: state_nxt = WAIT_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      bus.grant     <= '0;
      bus.ram_en    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      if (arb_en && win_found) begin
        bus.grant    <= NUM_REQ'(1) << win_idx;
        bus.ram_en   <= 1'b1;
        bus.ram_addr <= addr_full[ADDR_WIDTH-1:0];
        rr_ptr       <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        bus.grant  <= '0;
        bus.ram_en <= 1'b0;
      end

      // Tag travels alongside the read so each in-flight word keeps its owner.
      tag_pipe[0] <= bus.grant;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end

      bus.rsp_valid <= tag_pipe[RAM_LATENCY-1];
      if (|tag_pipe[RAM_LATENCY-1]) begin
        bus.rsp_data <= bus.ram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_spk_ram_arbiter.sv
// tb/tb_spk_ram_arbiter.sv - directed bench for spk_ram_arbiter at RAM latency 1 and 2
module tb_spk_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pre = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] eng_done = '0;
  logic [5:0] ts_of [4];
  logic [2:0] ic_of [4];
  logic [23:0] req_ts_v;
  logic [11:0] req_ic_v;
  logic post_a, busy_a, post_b, busy_b;
  logic [119:0] rd_a, rd_b;
  logic pb_en = 1'b0;
  logic [4:0] pb_addr = '0;

  int total = 0;
  int bad = 0;
  int gq [2][$];
  int rsp_cnt [2][4];

  always #5 clk = ~clk;

  spk_ram_arbiter_if ifa ();
  spk_ram_arbiter_if ifb ();

  always_comb begin
    req_ts_v = '0;
    req_ic_v = '0;
    for (int i = 0; i < 4; i++) begin
      req_ts_v[i*6 +: 6] = ts_of[i];
      req_ic_v[i*3 +: 3] = ic_of[i];
    end
  end

  assign ifa.req = req;       assign ifb.req = req;
  assign ifa.req_ts = req_ts_v; assign ifb.req_ts = req_ts_v;
  assign ifa.req_ic = req_ic_v; assign ifb.req_ic = req_ic_v;
  assign ifa.eng_done = eng_done; assign ifb.eng_done = eng_done;
  assign ifa.ram_rdata = rd_a;  assign ifb.ram_rdata = rd_b;

  spk_ram_arbiter #(.RAM_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pre_syn_RAM_loaded(pre), .bus(ifa),
    .post_syn_RAM_loaded(post_a), .busy(busy_a)
  );
  spk_ram_arbiter #(.RAM_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pre_syn_RAM_loaded(pre), .bus(ifb),
    .post_syn_RAM_loaded(post_b), .busy(busy_b)
  );

  function automatic logic [119:0] word(input logic [4:0] a);
    return {24'(a) + 24'h5A0000, 32'hDEAD0000 | 32'(a), 32'h01234567 + 32'(a), ~32'(a)};
  endfunction

  function automatic logic [4:0] exp_addr(input int w);
    return 5'(int'(ts_of[w]) * 2 + int'(ic_of[w]));
  endfunction

  // RAM models: one-cycle and two-cycle read latency.
  always @(posedge clk) if (ifa.ram_en) rd_a <= word(ifa.ram_addr);
  always @(posedge clk) begin
    pb_en   <= ifb.ram_en;
    pb_addr <= ifb.ram_addr;
    if (pb_en) rd_b <= word(pb_addr);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input logic [3:0] req_after);
    rst_n = 1'b0;
    step(2);
    for (int d = 0; d < 2; d++) begin
      gq[d].delete();
      for (int i = 0; i < 4; i++) rsp_cnt[d][i] = 0;
    end
    req = req_after;
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant_a"}, ifa.grant, 0);      chk({tag, "_grant_b"}, ifb.grant, 0);
    chk({tag, "_en_a"}, ifa.ram_en, 0);        chk({tag, "_en_b"}, ifb.ram_en, 0);
    chk({tag, "_addr_a"}, ifa.ram_addr, 0);    chk({tag, "_addr_b"}, ifb.ram_addr, 0);
    chk({tag, "_rv_a"}, ifa.rsp_valid, 0);     chk({tag, "_rv_b"}, ifb.rsp_valid, 0);
    chk({tag, "_rd_a"}, ifa.rsp_data, 0);      chk({tag, "_rd_b"}, ifb.rsp_data, 0);
    chk({tag, "_post_a"}, post_a, 0);          chk({tag, "_post_b"}, post_b, 0);
    chk({tag, "_busy_a"}, busy_a, 0);          chk({tag, "_busy_b"}, busy_b, 0);
  endtask

  // Response monitor: every observed grant must come back as a tagged word
  // exactly latency+1 cycles later, and nothing else may appear on rsp_valid.
  initial begin
    logic [3:0] slot_v [2][3];
    logic [4:0] slot_ad [2][3];
    logic [3:0] g, rv, en_g;
    logic [4:0] ad;
    logic [119:0] rd;
    int w;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) begin slot_v[d][k] = '0; slot_ad[d][k] = '0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        g  = (d == 0) ? ifa.grant : ifb.grant;
        rv = (d == 0) ? ifa.rsp_valid : ifb.rsp_valid;
        rd = (d == 0) ? ifa.rsp_data : ifb.rsp_data;
        ad = (d == 0) ? ifa.ram_addr : ifb.ram_addr;
        en_g = {3'b000, (d == 0) ? ifa.ram_en : ifb.ram_en};
        if (!rst_n)
          for (int k = 0; k < 3; k++) slot_v[d][k] = '0;
        chk("mon_rsp_valid", rv, slot_v[d][0]);
        if (slot_v[d][0] != 0) chk("mon_rsp_data", rd, word(slot_ad[d][0]));
        for (int i = 0; i < 4; i++) if (rv[i]) rsp_cnt[d][i]++;
        for (int k = 0; k < 2; k++) begin
          slot_v[d][k]  = slot_v[d][k+1];
          slot_ad[d][k] = slot_ad[d][k+1];
        end
        slot_v[d][2] = '0;
        chk("mon_ram_en", en_g, {3'b000, |g});
        if (g != 0) begin
          chk("mon_onehot", $countones(g), 1);
          w = 0;
          for (int i = 0; i < 4; i++) if (g[i]) w = i;
          gq[d].push_back(w);
          chk("mon_ram_addr", ad, exp_addr(w));
          slot_v[d][d + 1]  = g;
          slot_ad[d][d + 1] = exp_addr(w);
        end
      end
    end
  end

  initial begin
    ts_of[0] = 6'd3; ic_of[0] = 3'd1;   // address 7
    ts_of[1] = 6'd0; ic_of[1] = 3'd0;   // address 0
    ts_of[2] = 6'd5; ic_of[2] = 3'd1;   // address 11
    ts_of[3] = 6'd9; ic_of[3] = 3'd1;   // address 19

    // Reset state
    step(2);
    chk_all_zero("reset");

    // Gating: requests while the upstream RAM is not loaded are ignored
    rst_n = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("gate_grant_a", ifa.grant, 0);
      chk("gate_en_b", ifb.ram_en, 0);
    end
    pre = 1'b1;
    step(1);
    chk("single_grant_a", ifa.grant, 4'b0001);
    chk("single_grant_b", ifb.grant, 4'b0001);
    chk("single_addr_a", ifa.ram_addr, 7);
    chk("single_busy_a", busy_a, 1);
    step(1);
    chk("single_mask_a", ifa.grant, 0);
    req = 4'b0000;
    step(1);
    chk("single_rv_a", ifa.rsp_valid, 4'b0001);
    chk("single_rd_a", ifa.rsp_data, word(5'd7));
    step(1);
    chk("single_rv_b", ifb.rsp_valid, 4'b0001);
    chk("single_rd_b", ifb.rsp_data, word(5'd7));

    // Fairness: all four held for 12 arbitration cycles
    apply_reset(4'b1111);
    step(12);
    req = 4'b0000;
    step(5);
    for (int d = 0; d < 2; d++) begin
      chk("fair_count", gq[d].size(), 12);
      for (int i = 0; i < 12; i++)
        chk("fair_seq", (i < gq[d].size()) ? gq[d][i] : 99, i % 4);
      for (int i = 0; i < 4; i++) chk("fair_rsp_cnt", rsp_cnt[d][i], 3);
    end

    // Sparse contention: engines 2 and 3 only
    apply_reset(4'b1100);
    step(4);
    req = 4'b0000;
    step(5);
    for (int d = 0; d < 2; d++) begin
      chk("sparse_count", gq[d].size(), 4);
      for (int i = 0; i < 4; i++)
        chk("sparse_seq", (i < gq[d].size()) ? gq[d][i] : 99, (i % 2 == 0) ? 2 : 3);
      chk("sparse_idle0", rsp_cnt[d][0], 0);
      chk("sparse_idle1", rsp_cnt[d][1], 0);
      chk("sparse_cnt2", rsp_cnt[d][2], 2);
      chk("sparse_cnt3", rsp_cnt[d][3], 2);
    end

    // Completion with two reads in flight
    eng_done = 4'b0011;
    apply_reset(4'b0011);
    step(1);
    chk("done_grant0", ifb.grant, 4'b0001);
    eng_done = 4'b1111;
    step(1);
    chk("done_grant1", ifb.grant, 4'b0010);
    chk("done_busy_b", busy_b, 1);
    req = 4'b0000;
    step(1);
    chk("done_rv_a0", ifa.rsp_valid, 4'b0001);
    chk("done_post_a_early", post_a, 0);
    step(1);
    chk("done_rv_a1", ifa.rsp_valid, 4'b0010);
    chk("done_rv_b0", ifb.rsp_valid, 4'b0001);
    chk("done_post_a", post_a, 1);
    chk("done_busy_a", busy_a, 0);
    chk("done_post_b_early", post_b, 0);
    chk("done_busy_b_drain", busy_b, 1);
    step(1);
    chk("done_rv_b1", ifb.rsp_valid, 4'b0010);
    chk("done_post_b", post_b, 1);
    chk("done_busy_b_off", busy_b, 0);
    step(4);
    chk("done_hold_a", post_a, 1);
    chk("done_hold_b", post_b, 1);
    pre = 1'b0;
    #1;
    chk("done_hold_fall_a", post_a, 1);
    step(1);
    chk("done_clear_a", post_a, 0);
    chk("done_clear_b", post_b, 0);
    eng_done = 4'b0000;

    // Reset one cycle after a grant discards the in-flight read
    pre = 1'b1;
    apply_reset(4'b0001);
    step(1);
    chk("rst_grant_a", ifa.grant, 4'b0001);
    req = 4'b0000;
    step(1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    pre = 1'b0;
    step(2);
    rst_n = 1'b1;
    req = 4'b0001;
    step(4);
    chk("midrst_wait_grant", ifa.grant, 0);
    chk("midrst_wait_busy", busy_a, 0);
    chk("midrst_no_rsp", rsp_cnt[0][0] + rsp_cnt[1][0], 0);
    pre = 1'b1;
    step(1);
    chk("midrst_regrant", ifa.grant, 4'b0001);
    req = 4'b0000;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
